// File: rtl/press_generator_if.sv
// Bundles the request side and press-waveform side of press_generator.
// Latency: wires only, no delay.
// Backpressure: none; requests are accepted or counted, never stalled.
interface press_generator_if #(
    parameter int PW = 2
);
    logic          i_pulse_n;
    logic          i_clr_ovf;
    logic          o_output_n;
    logic          o_busy;
    logic [PW-1:0] o_pending;
    logic          o_overflow;

    modport master (
        output i_pulse_n,
        output i_clr_ovf,
        input  o_output_n,
        input  o_busy,
        input  o_pending,
        input  o_overflow
    );

    modport slave (
        input  i_pulse_n,
        input  i_clr_ovf,
        output o_output_n,
        output o_busy,
        output o_pending,
        output o_overflow
    );
endinterface

// File: rtl/press_generator.sv
// Turns active-low request pulses into HOLD-low / GAP-high press waveforms.
// Latency: output falls one edge after a request is sampled in IDLE.
// Backpressure: none; extra requests queue up to MAX_PENDING, then are dropped and flagged.
module press_generator #(
    parameter int  HOLD_CYCLES = 4,
    parameter int  GAP_CYCLES  = 2,
    parameter int  MAX_PENDING = 3,
    localparam int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    press_generator_if.slave bus
);
    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW     = (MAX_HG > 1) ? $clog2(MAX_HG) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;

    logic req;
    logic launch;
    logic ovf_set;

    assign req    = ~bus.i_pulse_n;
    assign launch = (state_q == ST_RELEASE) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        ovf_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_PRESS;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    if ((pending_q != '0) || req) begin
                        state_d = ST_PRESS;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A request coinciding with a launch feeds that launch directly, so the queue is untouched.
        if (state_q != ST_IDLE) begin
            if (req && !launch) begin
                if (pending_q < PEND_MAX) begin
                    pending_d = pending_q + PW'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (launch && !req && (pending_q != '0)) begin
                pending_d = pending_q - PW'(1);
            end
        end

        overflow_d = ovf_set | (overflow_q & ~bus.i_clr_ovf);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_output_n = (state_q != ST_PRESS);
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_pending  = pending_q;
    assign bus.o_overflow = overflow_q;
endmodule

// File: doc/press_generator.md
# press_generator

Converts single-cycle active-low request pulses into press waveforms: each press drives the output low for a fixed hold time, then high for a minimum release gap. Requests that arrive while a press is in progress are queued in a saturating counter. The block sits after the debounced-key logic of the vending controller and drives outputs that a debouncer samples, such as a dispense or solenoid line or an emulated key. It is the transmitting end of the button interface.

## Interface
- HOLD_CYCLES, 4: number of cycles `o_output_n` is held low per press; must be ≥1.
- GAP_CYCLES, 2: minimum number of cycles `o_output_n` is high between presses; must be ≥1.
- MAX_PENDING, 3: depth of the queued-request counter; must be ≥1.
- PW, $clog2(MAX_PENDING+1): width of `o_pending` (derived, not overridden).
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_pulse_n  in  1  request, active-low; every sampled low cycle is one request.
- i_clr_ovf  in  1  active-high synchronous clear of `o_overflow`.
- o_output_n  out  1  press waveform, active-low.
- o_busy  out  1  high whenever the state is not IDLE.
- o_pending  out  PW  number of queued requests.
- o_overflow  out  1  sticky flag: a request was dropped.

## Operation
- FSM states are IDLE, PRESS, RELEASE. A down-counter of width $clog2(max(HOLD,GAP)) times the PRESS and RELEASE states.
- Outputs are decoded from registers only, with no combinational path from inputs to outputs:
  - `o_output_n` is 0 only in PRESS.
  - `o_busy` is 0 only in IDLE.
- IDLE:
  - On a request, go to PRESS and load the counter with HOLD_CYCLES-1.
  - This request is consumed directly; `o_pending` does not change.
- PRESS:
  - Decrement the counter each cycle.
  - At 0, go to RELEASE and load the counter with GAP_CYCLES-1.
- RELEASE:
  - Decrement the counter each cycle.
  - At 0, if `o_pending`>0 or a request is present this cycle, go to PRESS with the counter loaded with HOLD_CYCLES-1. Otherwise go to IDLE.
- Pending bookkeeping, evaluated per cycle in PRESS and RELEASE (request = i_pulse_n==0; launch = RELEASE with counter==0):
  - Request, no launch: if `o_pending`<MAX_PENDING, increment it. Otherwise hold it and set `o_overflow`.
  - Launch, no request: decrement `o_pending` if it is >0.
  - Launch and request with `o_pending`>0: `o_pending` is unchanged, because the increment and decrement cancel. No overflow.
  - Launch and request with `o_pending`==0: the request is consumed directly by the new press; `o_pending` stays 0.
- `o_overflow`:
  - Set by a dropped request.
  - Cleared by `i_clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, including mid-press):
  - State=IDLE, counter=0.
  - `o_output_n`=1, `o_busy`=0, `o_pending`=0, `o_overflow`=0.
  - Queued requests are discarded.
  - The output returns high immediately, without waiting for a clock edge.
- `i_pulse_n` is assumed synchronous to `i_clk`. The block contains no synchronizer.

## Timing
- Let E0 be the edge that samples a request in IDLE.
- `o_output_n` goes low after E0: one-edge latency.
- It stays low for exactly HOLD_CYCLES cycles, through E0+HOLD_CYCLES.
- It stays high for exactly GAP_CYCLES cycles when back-to-back presses are queued. The next press begins after edge E0+HOLD_CYCLES+GAP_CYCLES.
- Press period under backlog is HOLD_CYCLES+GAP_CYCLES cycles; the defaults give 6.
- With nothing queued, the FSM is in IDLE after E0+HOLD_CYCLES+GAP_CYCLES, and `o_busy` falls at that point.
- A request in the final RELEASE cycle chains straight into PRESS. There is no IDLE cycle, and `o_busy` stays 1.
- `o_pending` and `o_overflow` update on the same edge that samples the request.

## Test plan
Defaults throughout: HOLD=4, GAP=2, MAX=3.

- Single pulse at E0 from IDLE:
  - `o_output_n` is low after E0..E4 and high after E4.
  - `o_busy` is 1 after E0..E6 and 0 after E6.
  - `o_pending` stays 0.
- Pulses at E0, E1, E2:
  - `o_pending` is 1 then 2.
  - Three 4-cycle lows start after E0, E6 and E12, with 2-cycle high gaps between them.
  - After E18: IDLE, `o_pending`=0.
- Five consecutive pulses E0–E4:
  - `o_pending` saturates at 3, and `o_overflow`=1 after E4.
  - Exactly 4 presses occur.
  - `i_clr_ovf` then clears the flag, except in a cycle with a simultaneous dropped request, where the flag stays 1.
- Single pulse at E0, then a pulse in the final RELEASE cycle (E5), with `o_pending`=0:
  - The second press starts after E6 with no IDLE gap.
  - `o_busy` never drops.
  - `o_pending` stays 0.
- Backlog with `o_pending`=3 and a request in the final RELEASE cycle:
  - `o_pending` stays 3.
  - `o_overflow` stays 0.
- Assert `i_rst` low mid-PRESS, with `o_pending`=2:
  - `o_output_n`=1 and all outputs are cleared before the next edge.
  - After release, a single pulse produces a normal 4-cycle press with no residual queued presses.
